seq_det_ctrl: RTL and testbench

Run controller for a programmable serial bit-pattern detector.
- Holds the pattern configuration.
- Gates the incoming bit stream with a valid/ready handshake.
- Sequences arm, run and done.
- Counts matches and raises an interrupt when a programmable match threshold is reached.
- Sits between the software-facing config interface and the serial data source, replacing hard-wired single-pattern detectors.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_match_core.sv | 66 ++++++
 rtl/seq_det_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the seq_det_ctrl pattern-detector slice.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // Length fields must hold the value PAT_W itself, hence the extra bit.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked pattern compare for seq_det_ctrl.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic             shift_en,
  input  logic             clr_fill,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             match_next
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;

  // Compare is made against the post-shift view so a match reports on the accepting edge.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], din};
    fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match_next = shift_en && (len != '0) && (fill_inc >= len) &&
                 ((hist_shift & mask) == (pattern & mask));
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_all) begin
      hist_d = '0;
      fill_d = '0;
    end else begin
      if (shift_en) begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end else begin
        fill_d = fill_q;
      end
      if (clr_fill) begin
        fill_d = '0;
      end else begin
        hist_d = hist_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the programmable serial pattern detector.
// Optional idle-gap timeout is built when SEQ_DET_TIMEOUT_EN is defined.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W       = PAT_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic [len_w(PAT_W)-1:0]  cfg_len,
  input  logic                     cfg_overlap,
  input  logic [CNT_W-1:0]         cfg_thresh,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     match_pulse,
  output logic [CNT_W-1:0]         match_count,
  output logic                     busy,
  output logic                     done,
  output logic                     irq,
  output logic                     timeout
);

  localparam int LEN_W = len_w(PAT_W);

  ctrl_state_t      state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             match_pulse_q, match_pulse_d;
  logic             din_ready_q, din_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             irq_q, irq_d;
  logic             timeout_q, timeout_d;
  logic             accept, go, match_next, thr_hit, clr_fill, to_hit;

  assign accept  = din_valid && din_ready_q;
  assign go      = start && !stop && (state_q != RUN);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign thr_hit = match_next && (thr_q != '0) && (cnt_inc == thr_q);
  assign clr_fill = to_hit || (match_next && !ovl_q);

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .clr_all    (go),
    .shift_en   (accept),
    .clr_fill   (clr_fill),
    .din        (din),
    .pattern    (pat_q),
    .len        (len_q),
    .match_next (match_next)
  );

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
  logic [GAP_W-1:0] gap_q, gap_d;

  always_comb begin
    to_hit = 1'b0;
    gap_d  = '0;
    if ((state_q == RUN) && !din_valid) begin
      if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
        to_hit = 1'b1;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end else begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end
`else
  // No gap counter in this build; the parameter only shapes the interface.
  assign to_hit = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  // Stop outranks both start and a threshold hit on the same edge.
  always_comb begin
    case (state_q)
      IDLE:    state_d = go ? RUN : IDLE;
      RUN: begin
        if (stop)         state_d = IDLE;
        else if (thr_hit) state_d = DONE;
        else              state_d = RUN;
      end
      DONE:    state_d = go ? RUN : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready_d = (state_d == RUN);
    busy_d      = (state_d == RUN);
    done_d      = (state_d == DONE);
    irq_d       = (state_q == RUN) && (state_d == DONE);
    timeout_d   = to_hit;
  end

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    thr_d = thr_q;
    if (cfg_we && (state_q != RUN)) begin
      pat_d = cfg_pattern;
      len_d = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
      ovl_d = cfg_overlap;
      thr_d = cfg_thresh;
    end else begin
      pat_d = pat_q;
    end
    if (go)              cnt_d = '0;
    else if (match_next) cnt_d = cnt_inc;
    else                 cnt_d = cnt_q;
    match_pulse_d = match_next;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q         <= '0;
      len_q         <= '0;
      ovl_q         <= 1'b0;
      thr_q         <= '0;
      cnt_q         <= '0;
      match_pulse_q <= 1'b0;
      din_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      irq_q         <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      pat_q         <= pat_d;
      len_q         <= len_d;
      ovl_q         <= ovl_d;
      thr_q         <= thr_d;
      cnt_q         <= cnt_d;
      match_pulse_q <= match_pulse_d;
      din_ready_q   <= din_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      irq_q         <= irq_d;
      timeout_q     <= timeout_d;
    end
  end

  assign din_ready   = din_ready_q;
  assign match_pulse = match_pulse_q;
  assign match_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign irq         = irq_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl; expects SEQ_DET_TIMEOUT_EN to match the RTL build.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int TO_CYC = 64;
`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif

  logic             clk = 1'b0;
  logic             rst, cfg_we, cfg_overlap, start, stop, din, din_valid;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic [CNT_W-1:0] cfg_thresh;
  logic             din_ready, match_pulse, busy, done, irq, timeout;
  logic [CNT_W-1:0] match_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int irq_seen = 0;
  int to_seen = 0;
  int exp_q[$];
  int irq0, to0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
    .start(start), .stop(stop), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .match_pulse(match_pulse), .match_count(match_count),
    .busy(busy), .done(done), .irq(irq), .timeout(timeout)
  );

  // Monitor: every match_pulse must correspond to the oldest expected match.
  always @(negedge clk) begin
    int e;
    if (match_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL match_sb: unexpected match_pulse, count=%0d, expected no match", match_count);
      end else begin
        e = exp_q.pop_front();
        if (match_count !== CNT_W'(e)) begin
          errors++;
          $display("FAIL match_sb: match_count=%0d, expected %0d", match_count, e);
        end
      end
    end
    if (irq === 1'b1) irq_seen++;
    if (timeout === 1'b1) to_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic m);
    din = b;
    din_valid = 1'b1;
    if (m) begin
      exp_cnt++;
      exp_q.push_back(exp_cnt);
    end
    tick();
    din_valid = 1'b0;
  endtask

  // Bits are sent MSB first (oldest first); m flags the bits expected to complete a match.
  task automatic send_stream(input logic [15:0] bits, input int n, input logic [15:0] m);
    for (int i = n - 1; i >= 0; i--) send(bits[i], m[i]);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    cfg_thresh = t;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic drain(input string name);
    tick();
    tick();
    chk(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_overlap = 1'b0;
    cfg_thresh = 8'd0; start = 1'b0; stop = 1'b0; din = 1'b0; din_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", din_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_irq", irq, 32'd0);
    chk("rst_match", match_pulse, 32'd0);
    chk("rst_count", match_count, 32'd0);
    chk("rst_timeout", timeout, 32'd0);
    rst = 1'b0;
    tick();

    // Overlapping matches
    cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0);
    go();
    chk("t1_busy", busy, 32'd1);
    chk("t1_ready", din_ready, 32'd1);
    send_stream(16'b101_1011, 7, 16'b000_1001);
    drain("t1_sb_empty");
    chk("t1_count", match_count, 32'd2);
    chk("t1_done", done, 32'd0);
    stop_run();
    chk("t1_stop_busy", busy, 32'd0);
    chk("t1_stop_ready", din_ready, 32'd0);
    chk("t1_held_count", match_count, 32'd2);

    // Non-overlapping matches
    cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0);
    go();
    chk("t2_count_clr", match_count, 32'd0);
    send_stream(16'b101_1011, 7, 16'b000_1000);
    drain("t2_sb_empty");
    chk("t2_count", match_count, 32'd1);
    stop_run();

    // Threshold with stalled input
    cfg(8'b0000_0011, 4'd2, 1'b1, 8'd2);
    irq0 = irq_seen;
    go();
    send(1'b1, 1'b0);
    tick();
    send(1'b1, 1'b1);
    tick();
    send(1'b1, 1'b1);
    chk("t3_ready", din_ready, 32'd0);
    chk("t3_done", done, 32'd1);
    chk("t3_busy", busy, 32'd0);
    chk("t3_irq", irq, 32'd1);
    send(1'b1, 1'b0);
    chk("t3_count", match_count, 32'd2);
    drain("t3_sb_empty");
    chk("t3_irq_once", irq_seen - irq0, 32'd1);
    chk("t3_done_held", done, 32'd1);

    // Restart from DONE, then start+stop together in RUN
    go();
    chk("t4_restart_busy", busy, 32'd1);
    chk("t4_restart_done", done, 32'd0);
    chk("t4_restart_count", match_count, 32'd0);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t4_ss_busy", busy, 32'd0);
    chk("t4_ss_ready", din_ready, 32'd0);

    // Stop on the same edge as the threshold-hitting bit
    irq0 = irq_seen;
    go();
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    stop = 1'b1;
    send(1'b1, 1'b1);
    stop = 1'b0;
    chk("t4_stop_busy", busy, 32'd0);
    chk("t4_stop_done", done, 32'd0);
    chk("t4_stop_count", match_count, 32'd2);
    drain("t4_sb_empty");
    chk("t4_no_irq", irq_seen - irq0, 32'd0);

    // Config writes ignored in RUN, then reset mid-run
    cfg(8'b0000_0011, 4'd2, 1'b1, 8'd0);
    go();
    cfg(8'b0000_0000, 4'd2, 1'b1, 8'd0);
    send_stream(16'b1111, 4, 16'b0111);
    drain("t5_sb_empty");
    chk("t5_count", match_count, 32'd3);
    rst = 1'b1;
    tick();
    chk("t5_rst_count", match_count, 32'd0);
    chk("t5_rst_ready", din_ready, 32'd0);
    chk("t5_rst_busy", busy, 32'd0);
    rst = 1'b0;
    exp_q.delete();

    // After reset len=0, which never matches
    go();
    send_stream(16'b11, 2, 16'b00);
    drain("t5_len0_sb");
    chk("t5_len0_count", match_count, 32'd0);
    stop_run();

    // Oversized length clamps to PAT_W
    cfg(8'hA5, 4'd15, 1'b0, 8'd0);
    go();
    send_stream(16'h00A5, 8, 16'h0001);
    drain("clamp_sb_empty");
    chk("clamp_count", match_count, 32'd1);
    stop_run();

    // Idle gap of TIMEOUT_CYC cycles inside a partial pattern
    cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0);
    go();
    to0 = to_seen;
    send_stream(16'b101, 3, 16'b000);
    repeat (TO_CYC) tick();
    send(1'b1, (TO_EN == 0));
    drain("t6_sb_empty");
    chk("t6_timeout", to_seen - to0, TO_EN);
    chk("t6_count", match_count, (TO_EN == 0) ? 32'd1 : 32'd0);
    stop_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
